// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 requester: FSM states, PPROT bit positions
// and the width of the per-transfer timeout counter.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [2:0] PPROT_PRIV   = 3'b001;
    localparam logic [2:0] PPROT_NONSEC = 3'b010;
    localparam logic [2:0] PPROT_INSTR  = 3'b100;

    localparam int unsigned TO_CNT_W = 32;

endpackage : apb_pkg

// File: rtl/apb_requester.sv
// APB4 initiator: one valid/ready request becomes one APB transfer whose result
// is returned on a valid/ready response channel, with an optional wait timeout.
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_write,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [2:0]          req_prot,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                resp_timeout,
    output logic [ADDR_W-1:0]   out_paddr,
    output logic                out_psel,
    output logic                out_penable,
    output logic [2:0]          out_pprot,
    output logic                out_pwrite,
    output logic [DATA_W-1:0]   out_pwdata,
    output logic [DATA_W/8-1:0] out_pstrb,
    input  logic                out_pready,
    input  logic [DATA_W-1:0]   out_prdata,
    input  logic                out_pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam bit TO_EN = (TIMEOUT != 0);
    // Last ACCESS cycle index still allowed to wait; only meaningful when TO_EN.
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [2:0]          pprot_q, pprot_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rerr_q, rerr_d;
    logic                rto_q, rto_d;

    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = rvalid_q;
    assign resp_rdata   = rdata_q;
    assign resp_err     = rerr_q;
    assign resp_timeout = rto_q;
    assign out_paddr    = paddr_q;
    assign out_psel     = psel_q;
    assign out_penable  = penable_q;
    assign out_pprot    = pprot_q;
    assign out_pwrite   = pwrite_q;
    assign out_pwdata   = pwdata_q;
    assign out_pstrb    = pstrb_q;

    // Next-state logic for the transfer FSM, APB outputs, counter and response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pprot_d   = pprot_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        rto_d     = rto_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d   = ST_SETUP;
                    cnt_d     = '0;
                    paddr_d   = req_addr;
                    pwrite_d  = req_write;
                    pprot_d   = req_prot;
                    pwdata_d  = req_write ? req_wdata : '0;
                    pstrb_d   = req_write ? req_wstrb : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                // A ready slave wins over a timeout landing in the same cycle.
                if (out_pready) begin
                    state_d   = ST_RESP;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = pwrite_q ? '0 : out_prdata;
                    rerr_d    = out_pslverr;
                    rto_d     = 1'b0;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d   = ST_RESP;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = '0;
                    rerr_d    = 1'b1;
                    rto_d     = 1'b1;
                end else if (cnt_q != {TO_CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + TO_CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pprot_q   <= 3'b000;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
            rto_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pprot_q   <= pprot_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
            rto_q     <= rto_d;
        end
    end

endmodule : apb_requester
